// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: default widths and state encoding.
package serial_subtractor_pkg;

  localparam int unsigned ARITH_W     = 16;
  localparam int unsigned ARITH_CNT_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell, the mirror of the full adder cell.
// Ports: A - B - Bin -> difference D, borrow-out Bout.
module full_subtractor (
  output logic Bout,
  output logic D,
  input  logic A,
  input  logic B,
  input  logic Bin
);

  assign D    = A ^ B ^ Bin;
  // Borrow when A is 0 and B is 1, or A equals B and a borrow is already owed.
  assign Bout = (~A & B) | (~(A ^ B) & Bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial A - B - Bin subtractor, one bit per clock, LSB first.
// Ports: clk, rst_n (sync, active-low); start/A/B/Bin request (sampled while ready);
//        ready, busy, done (one-cycle pulse), D difference, Bout final borrow.
// Optional: define SERIAL_SUBTRACTOR_OVF_EN to add V, the signed overflow flag.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int unsigned WIDTH = ARITH_W,
  parameter int unsigned CNT_W = ARITH_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] D,
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  output logic             V,
`endif
  output logic             Bout
);

  state_t             state_q;
  logic [WIDTH-1:0]   opa_q, opb_q, res_q;
  logic [WIDTH-1:0]   res_d;
  logic               borrow_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               ready_q, busy_q, done_q, bout_q;
  logic [WIDTH-1:0]   d_q;
  logic               d_c, nb_c;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic               v_q;
`endif

  // Single subtractor cell working on the current LSBs.
  full_subtractor u_cell (
    .Bout (nb_c),
    .D    (d_c),
    .A    (opa_q[0]),
    .B    (opb_q[0]),
    .Bin  (borrow_q)
  );

  // Difference bits enter at the MSB so the LSB ends up at bit 0 after WIDTH shifts.
  assign res_d = {d_c, res_q[WIDTH-1:1]};

  // Control FSM and datapath; all outputs registered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      opa_q    <= '0;
      opb_q    <= '0;
      res_q    <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      d_q      <= '0;
      bout_q   <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      v_q      <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            opa_q    <= A;
            opb_q    <= B;
            borrow_q <= Bin;
            cnt_q    <= '0;
            state_q  <= ST_RUN;
            ready_q  <= 1'b0;
            busy_q   <= 1'b1;
          end else begin
            state_q  <= ST_IDLE;
          end
        end
        ST_RUN: begin
          opa_q    <= opa_q >> 1;
          opb_q    <= opb_q >> 1;
          res_q    <= res_d;
          borrow_q <= nb_c;
          cnt_q    <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_q <= ST_DONE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            d_q     <= res_d;
            bout_q  <= nb_c;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            // Borrow into the MSB differs from borrow out of it on signed overflow.
            v_q     <= borrow_q ^ nb_c;
`endif
          end
        end
        default: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ready = ready_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign D     = d_q;
  assign Bout  = bout_q;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  assign V     = v_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: timeline model plus directed vectors.
module tb_serial_subtractor;

  localparam int unsigned WIDTH = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [WIDTH-1:0] A = '0;
  logic [WIDTH-1:0] B = '0;
  logic             Bin = 1'b0;
  logic             ready, busy, done, Bout;
  logic [WIDTH-1:0] D;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic             V;
`endif

  serial_subtractor dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (A),
    .B     (B),
    .Bin   (Bin),
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .D     (D),
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    .V     (V),
`endif
    .Bout  (Bout)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: an accepted request keeps the block busy for WIDTH cycles, then the
  // arithmetic result appears with a one-cycle done pulse and is held.
  int               m_run_left = 0;
  logic             m_done = 1'b0;
  logic [WIDTH-1:0] m_D = '0;
  logic             m_bout = 1'b0;
  logic [WIDTH:0]   m_pend = '0;
  logic             m_v = 1'b0;
  logic             m_v_pend = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_run_left = 0;
      m_done     = 1'b0;
      m_D        = '0;
      m_bout     = 1'b0;
      m_v        = 1'b0;
    end else if (m_run_left > 0) begin
      m_run_left = m_run_left - 1;
      m_done     = (m_run_left == 0);
      if (m_done) begin
        {m_bout, m_D} = m_pend;
        m_v = m_v_pend;
      end
    end else begin
      m_done = 1'b0;
      if (start) begin
        int r;
        m_pend     = {1'b0, A} - {1'b0, B} - (WIDTH+1)'(Bin);
        r          = int'($signed(A)) - int'($signed(B)) - int'(Bin);
        m_v_pend   = (r < -(1 << (WIDTH-1))) || (r > (1 << (WIDTH-1)) - 1);
        m_run_left = WIDTH;
      end
    end
  end

  // Every-cycle comparison against the model, sampled mid-cycle.
  logic cmp_en = 1'b0;
  always @(negedge clk) begin
    if (cmp_en) begin
      check("ready", 32'(ready), 32'(m_run_left == 0));
      check("busy",  32'(busy),  32'(m_run_left > 0));
      check("done",  32'(done),  32'(m_done));
      check("D",     32'(D),     32'(m_D));
      check("Bout",  32'(Bout),  32'(m_bout));
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      check("V",     32'(V),     32'(m_v));
`endif
    end
  end

  // Issue one request and wait for done; returns cycles from request to done and busy count.
  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic bin,
                        output int cycles, output int busy_cnt);
    @(negedge clk);
    A = a; B = b; Bin = bin; start = 1'b1;
    cycles = 0; busy_cnt = 0;
    do begin
      @(negedge clk);
      start = 1'b0;
      cycles++;
      if (busy) busy_cnt++;
    end while (!done && cycles < 40);
    if (!done) check("done_timeout", 32'(done), 32'd1);
  endtask

  int cyc, bcnt;

  initial begin
    repeat (2) @(posedge clk);
    cmp_en = 1'b1;
    @(negedge clk);
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_busy",  32'(busy),  32'd0);
    check("rst_D",     32'(D),     32'd0);
    rst_n = 1'b1;

    run_op(16'h1234, 16'h0034, 1'b0, cyc, bcnt);
    check("t1_D", 32'(D), 32'h1200);
    check("t1_Bout", 32'(Bout), 32'd0);
    check("t1_latency", 32'(cyc), 32'd17);
    check("t1_busy_cycles", 32'(bcnt), 32'd16);

    run_op(16'h0000, 16'h0001, 1'b0, cyc, bcnt);
    check("t2_D", 32'(D), 32'hFFFF);
    check("t2_Bout", 32'(Bout), 32'd1);

    run_op(16'h5555, 16'h5555, 1'b1, cyc, bcnt);
    check("t3_D", 32'(D), 32'hFFFF);
    check("t3_Bout", 32'(Bout), 32'd1);

    // Back-to-back: hold start through the DONE cycle with new operands.
    run_op(16'h0100, 16'h0001, 1'b0, cyc, bcnt);
    check("b2b_first_D", 32'(D), 32'h00FF);
    A = 16'hFFFF; B = 16'h0001; Bin = 1'b0; start = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      start = 1'b0;
      cyc++;
      if (cyc == 8) check("b2b_hold_D", 32'(D), 32'h00FF);
    end while (!done && cyc < 40);
    if (!done) check("b2b_timeout", 32'(done), 32'd1);
    check("b2b_gap", 32'(cyc), 32'd17);
    check("b2b_D", 32'(D), 32'hFFFE);
    check("b2b_Bout", 32'(Bout), 32'd0);

    // Start pulses during RUN with other operands must be ignored.
    @(negedge clk);
    A = 16'h0009; B = 16'h0004; Bin = 1'b0; start = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      A = 16'hABCD; B = 16'h1111; Bin = 1'b1;
      start = (i % 2 == 0);
    end
    start = 1'b0;
    cyc = 0;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    if (!done) check("ign_timeout", 32'(done), 32'd1);
    check("ign_D", 32'(D), 32'h0005);
    check("ign_Bout", 32'(Bout), 32'd0);

    // Reset in the middle of an operation.
    @(negedge clk);
    A = 16'h1234; B = 16'h0001; Bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_done",  32'(done),  32'd0);
    check("abort_ready", 32'(ready), 32'd1);
    check("abort_D",     32'(D),     32'd0);
    check("abort_Bout",  32'(Bout),  32'd0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("abort_no_done", 32'(done), 32'd0);
    run_op(16'h0010, 16'h0001, 1'b0, cyc, bcnt);
    check("post_rst_D", 32'(D), 32'h000F);

`ifdef SERIAL_SUBTRACTOR_OVF_EN
    run_op(16'h8000, 16'h0001, 1'b0, cyc, bcnt);
    check("ovf1_D", 32'(D), 32'h7FFF);
    check("ovf1_V", 32'(V), 32'd1);
    check("ovf1_Bout", 32'(Bout), 32'd0);
    run_op(16'h7FFF, 16'h0001, 1'b0, cyc, bcnt);
    check("ovf2_D", 32'(D), 32'h7FFE);
    check("ovf2_V", 32'(V), 32'd0);
`endif

    repeat (3) @(negedge clk);
    cmp_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
